// File: rtl/dma_read_cmd_arbiter.sv
// Round-robin arbiter sharing one DMA read command/data path between NUM_REQ requesters.
// Issued requester ids are queued so returned bursts are steered back in issue order.
module dma_read_cmd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 32,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          net_clk,
  input  logic                          net_reset,
  input  logic [NUM_REQ-1:0]            s_cmd_valid,
  output logic [NUM_REQ-1:0]            s_cmd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     s_cmd_address,
  input  logic [NUM_REQ*LEN_W-1:0]      s_cmd_length,
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  output logic [ADDR_W-1:0]             m_cmd_address,
  output logic [LEN_W-1:0]              m_cmd_length,
  input  logic                          s_data_valid,
  output logic                          s_data_ready,
  input  logic [DATA_W-1:0]             s_data_data,
  input  logic [DATA_W/8-1:0]           s_data_keep,
  input  logic                          s_data_last,
  output logic [NUM_REQ-1:0]            m_data_valid,
  input  logic [NUM_REQ-1:0]            m_data_ready,
  output logic [DATA_W-1:0]             m_data_data,
  output logic [DATA_W/8-1:0]           m_data_keep,
  output logic                          m_data_last,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic [31:0]                   dropped_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0]     ptr_q, ptr_d;
  logic              mv_q, mv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [31:0]       drop_q, drop_d;
  logic [IW-1:0]     tag_mem [TAG_DEPTH];

  logic [IW-1:0]     gnt, idx, head;
  logic              gnt_vld, slot_free, full, empty, accept, hs, push, pop, zero_len;
  logic [LEN_W-1:0]  gnt_len;
  logic [ADDR_W-1:0] gnt_addr;

  // Scan from farthest to nearest so the requester closest after ptr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (s_cmd_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign gnt_len   = s_cmd_length[int'(gnt)*LEN_W +: LEN_W];
  assign gnt_addr  = s_cmd_address[int'(gnt)*ADDR_W +: ADDR_W];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(TAG_DEPTH));
  assign slot_free = !mv_q || m_cmd_ready;
  // Ready is withheld during reset so no requester sees a handshake that is thrown away.
  assign accept    = slot_free && !full && !net_reset;
  assign hs        = accept && gnt_vld;
  assign push      = hs && (gnt_len != '0);
  assign zero_len  = hs && (gnt_len == '0);

  assign head         = tag_mem[rp_q];
  assign s_data_ready = !empty && m_data_ready[head];
  assign pop          = s_data_valid && s_data_ready && s_data_last;

  always_comb begin
    s_cmd_ready = '0;
    if (hs) s_cmd_ready[gnt] = 1'b1;
  end

  always_comb begin
    m_data_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      m_data_valid[i] = s_data_valid && !empty && (head == IW'(i));
  end

  always_comb begin
    ptr_d  = ptr_q;
    mv_d   = mv_q;
    addr_d = addr_q;
    len_d  = len_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (hs) ptr_d = gnt;
    if (push) begin
      mv_d   = 1'b1;
      addr_d = gnt_addr;
      len_d  = gnt_len;
      wp_d   = wp_q + 1'b1;
    end else if (slot_free) begin
      mv_d = 1'b0;
    end
    if (zero_len && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (pop) rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge net_clk) begin
    if (net_reset) begin
      ptr_q  <= IW'(NUM_REQ - 1);
      mv_q   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      mv_q   <= mv_d;
      addr_q <= addr_d;
      len_q  <= len_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge net_clk) begin
    if (push) tag_mem[wp_q] <= gnt;
  end

  assign m_cmd_valid   = mv_q;
  assign m_cmd_address = addr_q;
  assign m_cmd_length  = len_q;
  assign m_data_data   = s_data_data;
  assign m_data_keep   = s_data_keep;
  assign m_data_last   = s_data_last;
  assign outstanding   = cnt_q;
  assign dropped_cnt   = drop_q;

endmodule

// File: tb/tb_dma_read_cmd_arbiter.sv
// Bench for dma_read_cmd_arbiter: vector table, directed corner sequences, random vs queue model.
module tb_dma_read_cmd_arbiter;
  localparam int NUM_REQ = 2, ADDR_W = 64, LEN_W = 32, DATA_W = 512, TAG_DEPTH = 16;
  localparam int KW = DATA_W / 8, OW = $clog2(TAG_DEPTH) + 1;

  logic                      net_clk = 1'b0, net_reset;
  logic [NUM_REQ-1:0]        s_cmd_valid, s_cmd_ready;
  logic [NUM_REQ*ADDR_W-1:0] s_cmd_address;
  logic [NUM_REQ*LEN_W-1:0]  s_cmd_length;
  logic                      m_cmd_valid, m_cmd_ready;
  logic [ADDR_W-1:0]         m_cmd_address;
  logic [LEN_W-1:0]          m_cmd_length;
  logic                      s_data_valid, s_data_ready, s_data_last, m_data_last;
  logic [DATA_W-1:0]         s_data_data, m_data_data;
  logic [KW-1:0]             s_data_keep, m_data_keep;
  logic [NUM_REQ-1:0]        m_data_valid, m_data_ready;
  logic [OW-1:0]             outstanding;
  logic [31:0]               dropped_cnt;

  int errors = 0, checks = 0;

  always #5 net_clk = ~net_clk;

  dma_read_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
                         .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .net_clk(net_clk), .net_reset(net_reset),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
    .s_data_data(s_data_data), .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .m_data_data(m_data_data), .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .outstanding(outstanding), .dropped_cnt(dropped_cnt)
  );

  typedef struct {
    logic [1:0]  vld;
    logic        mrdy;
    logic [31:0] len0, len1;
    logic [1:0]  rdy;
    logic        mvld;
    logic [63:0] addr;
    logic [31:0] len;
    int          out;
    int          drop;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge net_clk);
    #1;
  endtask

  task automatic idle;
    s_cmd_valid = '0; m_cmd_ready = 1'b0; s_data_valid = 1'b0; s_data_last = 1'b0;
    m_data_ready = '0; s_data_data = '0; s_data_keep = '0;
    s_cmd_address = {64'h2000, 64'h1000}; s_cmd_length = {32'd64, 32'd64};
  endtask

  // Reset with every requester and data input active; nothing may leak out.
  task automatic do_reset;
    idle();
    net_reset = 1'b1; s_cmd_valid = '1; s_data_valid = 1'b1; m_data_ready = '1; m_cmd_ready = 1'b1;
    tick(); tick();
    chk("rst_s_cmd_ready", s_cmd_ready, 0);
    chk("rst_s_data_ready", s_data_ready, 0);
    chk("rst_m_data_valid", m_data_valid, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_cmd_address", m_cmd_address, 0);
    chk("rst_m_cmd_length", m_cmd_length, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_dropped", dropped_cnt, 0);
    idle();
    net_reset = 1'b0;
  endtask

  // Behavioural model state: arbitration pointer, tag queue, command slot, drop counter.
  int          m_ptr;
  int          m_q[$];
  bit          m_mv;
  logic [63:0] m_addr;
  logic [31:0] m_len;
  longint      m_drop;

  initial begin
    tv[0] = '{2'b01, 1'b1, 32'd256, 32'd0,   2'b01, 1'b1, 64'h1000, 32'd256, 1, 0};
    tv[1] = '{2'b11, 1'b1, 32'd64,  32'd128, 2'b10, 1'b1, 64'h2000, 32'd128, 2, 0};
    tv[2] = '{2'b11, 1'b0, 32'd64,  32'd128, 2'b00, 1'b1, 64'h2000, 32'd128, 2, 0};
    tv[3] = '{2'b11, 1'b1, 32'd32,  32'd128, 2'b01, 1'b1, 64'h1000, 32'd32,  3, 0};
    tv[4] = '{2'b10, 1'b0, 32'd32,  32'd0,   2'b00, 1'b1, 64'h1000, 32'd32,  3, 0};
    tv[5] = '{2'b10, 1'b1, 32'd32,  32'd0,   2'b10, 1'b0, 64'h0,    32'd0,   3, 1};
    tv[6] = '{2'b00, 1'b0, 32'd32,  32'd0,   2'b00, 1'b0, 64'h0,    32'd0,   3, 1};
    tv[7] = '{2'b11, 1'b1, 32'd48,  32'd96,  2'b01, 1'b1, 64'h1000, 32'd48,  4, 1};
    tv[8] = '{2'b00, 1'b1, 32'd48,  32'd96,  2'b00, 1'b0, 64'h0,    32'd0,   4, 1};

    net_reset = 1'b1;
    idle();
    do_reset();

    // Vector table: priority rotation, hold under backpressure, zero-length drop.
    for (int r = 0; r < 9; r++) begin
      s_cmd_valid = tv[r].vld; m_cmd_ready = tv[r].mrdy;
      s_cmd_address = {64'h2000, 64'h1000}; s_cmd_length = {tv[r].len1, tv[r].len0};
      #1 chk($sformatf("tv%0d_s_cmd_ready", r), s_cmd_ready, tv[r].rdy);
      tick();
      chk($sformatf("tv%0d_m_cmd_valid", r), m_cmd_valid, tv[r].mvld);
      if (tv[r].mvld) begin
        chk($sformatf("tv%0d_m_cmd_address", r), m_cmd_address, tv[r].addr);
        chk($sformatf("tv%0d_m_cmd_length", r), m_cmd_length, tv[r].len);
      end
      chk($sformatf("tv%0d_outstanding", r), outstanding, tv[r].out);
      chk($sformatf("tv%0d_dropped", r), dropped_cnt, tv[r].drop);
    end

    // Reset mid-operation discards the four outstanding tags.
    do_reset();

    // Full tag FIFO: no acceptance, no bypass while a pop is in progress.
    s_cmd_valid = 2'b01; m_cmd_ready = 1'b1;
    for (int k = 0; k < TAG_DEPTH; k++) tick();
    chk("full_outstanding", outstanding, TAG_DEPTH);
    #1 chk("full_blocked", s_cmd_ready, 0);
    tick();
    chk("full_hold", outstanding, TAG_DEPTH);
    s_data_valid = 1'b1; s_data_last = 1'b1; m_data_ready = 2'b01;
    #1 chk("full_pop_sdr", s_data_ready, 1);
    chk("full_pop_mdv", m_data_valid, 2'b01);
    chk("full_no_bypass", s_cmd_ready, 0);
    tick();
    s_data_valid = 1'b0;
    chk("full_after_pop", outstanding, TAG_DEPTH - 1);
    #1 chk("full_reaccept", s_cmd_ready, 2'b01);
    tick();
    chk("full_refill", outstanding, TAG_DEPTH);

    do_reset();

    // In-order steering: req1 burst must drain before req0 data is visible.
    s_cmd_valid = 2'b10; m_cmd_ready = 1'b1; s_cmd_length = {32'd128, 32'd64};
    #1 chk("st_grant1", s_cmd_ready, 2'b10);
    tick();
    s_cmd_valid = 2'b01;
    #1 chk("st_grant0", s_cmd_ready, 2'b01);
    tick();
    s_cmd_valid = 2'b00;
    chk("st_outstanding2", outstanding, 2);
    s_data_valid = 1'b1; s_data_last = 1'b0; m_data_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("st_stall%0d_sdr", c), s_data_ready, 0);
      chk($sformatf("st_stall%0d_mdv", c), m_data_valid, 2'b10);
      tick();
    end
    m_data_ready = 2'b11;
    #1 chk("st_b1_mdv", m_data_valid, 2'b10);
    chk("st_b1_sdr", s_data_ready, 1);
    tick();
    s_data_last = 1'b1;
    #1 chk("st_b2_mdv", m_data_valid, 2'b10);
    tick();
    chk("st_after_req1", outstanding, 1);
    #1 chk("st_b3_mdv", m_data_valid, 2'b01);
    chk("st_b3_sdr", s_data_ready, 1);
    tick();
    chk("st_drained", outstanding, 0);
    #1 chk("st_unsolicited_sdr", s_data_ready, 0);
    chk("st_unsolicited_mdv", m_data_valid, 0);

    // Random traffic against a queue-based model of the arbitration and steering rules.
    do_reset();
    m_ptr = NUM_REQ - 1; m_q.delete(); m_mv = 0; m_addr = 0; m_len = 0; m_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic              sf, acc, esdr, popf;
      logic [NUM_REQ-1:0] erdy, emdv;
      int                g;
      logic [31:0]       glen;
      s_cmd_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        s_cmd_address[i*ADDR_W +: ADDR_W] = {$urandom, $urandom};
        s_cmd_length[i*LEN_W +: LEN_W] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      end
      m_cmd_ready  = ($urandom_range(0, 3) != 0);
      s_data_valid = ($urandom_range(0, 99) < ((cyc % 1000) < 500 ? 15 : 70));
      s_data_last  = ($urandom_range(0, 2) == 0);
      m_data_ready = NUM_REQ'($urandom);
      for (int w = 0; w < DATA_W / 32; w++) s_data_data[w*32 +: 32] = $urandom;
      s_data_keep  = {2{$urandom, $urandom}};

      sf  = !m_mv || m_cmd_ready;
      acc = sf && (m_q.size() < TAG_DEPTH);
      g = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (g < 0 && s_cmd_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      erdy = (acc && g >= 0) ? NUM_REQ'(1 << g) : '0;
      esdr = (m_q.size() > 0) && m_data_ready[m_q[0]];
      emdv = (s_data_valid && m_q.size() > 0) ? NUM_REQ'(1 << m_q[0]) : '0;

      #1 chk("rnd_s_cmd_ready", s_cmd_ready, erdy);
      chk("rnd_s_data_ready", s_data_ready, esdr);
      chk("rnd_m_data_valid", m_data_valid, emdv);
      chk("rnd_m_data_data", m_data_data, s_data_data);
      chk("rnd_m_data_keep", m_data_keep, s_data_keep);
      chk("rnd_m_data_last", m_data_last, s_data_last);

      popf = s_data_valid && esdr && s_data_last;
      if (acc && g >= 0) begin
        m_ptr = g;
        glen = s_cmd_length[g*LEN_W +: LEN_W];
        if (glen != 0) begin
          m_mv = 1; m_addr = s_cmd_address[g*ADDR_W +: ADDR_W]; m_len = glen;
          m_q.push_back(g);
        end else begin
          if (m_drop < 64'hFFFF_FFFF) m_drop++;
          m_mv = 0;
        end
      end else if (sf) begin
        m_mv = 0;
      end
      if (popf) void'(m_q.pop_front());

      tick();
      chk("rnd_m_cmd_valid", m_cmd_valid, m_mv);
      if (m_mv) begin
        chk("rnd_m_cmd_address", m_cmd_address, m_addr);
        chk("rnd_m_cmd_length", m_cmd_length, m_len);
      end
      chk("rnd_outstanding", outstanding, m_q.size());
      chk("rnd_dropped", dropped_cnt, m_drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
